// File: rtl/nn_batch_sequencer.sv
// Walks a batch of images from a label/image ROM through a neural network,
// scoring each argmax against its label and reporting per-image results.
module nn_batch_sequencer #(
    parameter int dataWidth     = 8,
    parameter int numInputs     = 784,
    parameter int numImages     = 8,
    parameter int timeoutCycles = 4096
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic [3:0]                     imgAddr,
    input  logic [numInputs*dataWidth-1:0] imgData,
    input  logic [3:0]                     imgLabel,
    output logic                           nnReset,
    output logic [numInputs*dataWidth-1:0] NNin,
    output logic                           NNvalid,
    input  logic                           maxValid,
    input  logic [3:0]                     maxIndex,
    input  logic [7:0]                     maxValue,
    output logic                           busy,
    output logic                           done,
    output logic                           resultValid,
    output logic [3:0]                     resultImg,
    output logic [3:0]                     resultClass,
    output logic [7:0]                     resultScore,
    output logic                           resultHit,
    output logic [4:0]                     correctCount,
    output logic                           timeoutErr
);

    localparam int            TW       = (timeoutCycles > 1) ? $clog2(timeoutCycles) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(timeoutCycles - 1);
    localparam logic [3:0]    IDX_LAST = 4'(numImages - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_WAIT   = 3'd3,
        S_RECORD = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t        state_r;
    logic [3:0]    idx_r;
    logic [3:0]    label_r;
    logic [TW-1:0] tmo_cnt_r;

    // The ROM address tracks idx directly, so it is already stable during FETCH.
    assign imgAddr = idx_r;

    // Batch sequencer FSM; all outputs are registered and set on entry to their state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            idx_r        <= 4'd0;
            label_r      <= 4'd0;
            tmo_cnt_r    <= '0;
            NNin         <= '0;
            nnReset      <= 1'b0;
            NNvalid      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            resultValid  <= 1'b0;
            resultImg    <= 4'd0;
            resultClass  <= 4'd0;
            resultScore  <= 8'd0;
            resultHit    <= 1'b0;
            correctCount <= 5'd0;
            timeoutErr   <= 1'b0;
        end else begin
            nnReset     <= 1'b0;
            done        <= 1'b0;
            resultValid <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        idx_r        <= 4'd0;
                        correctCount <= 5'd0;
                        timeoutErr   <= 1'b0;
                        nnReset      <= 1'b1;
                        busy         <= 1'b1;
                        state_r      <= S_FETCH;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    state_r <= S_LOAD;
                end
                S_LOAD: begin
                    NNin      <= imgData;
                    label_r   <= imgLabel;
                    tmo_cnt_r <= '0;
                    NNvalid   <= 1'b1;
                    state_r   <= S_WAIT;
                end
                S_WAIT: begin
                    // A network answer on the last allowed cycle still counts.
                    if (maxValid) begin
                        resultClass <= maxIndex;
                        resultScore <= maxValue;
                        resultHit   <= (maxIndex == label_r);
                        resultImg   <= idx_r;
                        resultValid <= 1'b1;
                        NNvalid     <= 1'b0;
                        state_r     <= S_RECORD;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        resultClass <= 4'hF;
                        resultScore <= 8'd0;
                        resultHit   <= 1'b0;
                        resultImg   <= idx_r;
                        resultValid <= 1'b1;
                        timeoutErr  <= 1'b1;
                        NNvalid     <= 1'b0;
                        state_r     <= S_RECORD;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end
                end
                S_RECORD: begin
                    if (resultHit) begin
                        correctCount <= correctCount + 5'd1;
                    end
                    if (idx_r == IDX_LAST) begin
                        done    <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        idx_r   <= idx_r + 4'd1;
                        nnReset <= 1'b1;
                        state_r <= S_FETCH;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    NNvalid <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_batch_sequencer.sv
// Randomized bench for nn_batch_sequencer: ROM and network models, an output
// monitor, and an abstract per-image result model checked after every batch.
module tb_nn_batch_sequencer;

    localparam int DW   = 8;
    localparam int NI   = 4;
    localparam int NIMG = 8;
    localparam int TMO  = 64;
    localparam int W    = DW * NI;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   imgAddr;
    logic [W-1:0] imgData;
    logic [3:0]   imgLabel;
    logic         nnReset;
    logic [W-1:0] NNin;
    logic         NNvalid;
    logic         maxValid;
    logic [3:0]   maxIndex;
    logic [7:0]   maxValue;
    logic         busy;
    logic         done;
    logic         resultValid;
    logic [3:0]   resultImg;
    logic [3:0]   resultClass;
    logic [7:0]   resultScore;
    logic         resultHit;
    logic [4:0]   correctCount;
    logic         timeoutErr;

    int checks   = 0;
    int failures = 0;

    nn_batch_sequencer #(
        .dataWidth(DW), .numInputs(NI), .numImages(NIMG), .timeoutCycles(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .imgAddr(imgAddr),
        .imgData(imgData), .imgLabel(imgLabel), .nnReset(nnReset), .NNin(NNin),
        .NNvalid(NNvalid), .maxValid(maxValid), .maxIndex(maxIndex),
        .maxValue(maxValue), .busy(busy), .done(done), .resultValid(resultValid),
        .resultImg(resultImg), .resultClass(resultClass), .resultScore(resultScore),
        .resultHit(resultHit), .correctCount(correctCount), .timeoutErr(timeoutErr)
    );

    always #5 clk = ~clk;

    // Per-image configuration: ROM contents and how the network answers.
    logic [W-1:0] rom_img [16];
    logic [3:0]   rom_lbl [16];
    int           lat     [16];
    logic [3:0]   cls     [16];
    logic [7:0]   val     [16];

    // Observations collected by the monitor.
    logic [3:0] ob_img[$];
    logic [3:0] ob_cls[$];
    logic [7:0] ob_score[$];
    logic       ob_hit[$];
    int         ob_wlen[$];
    int         done_cnt;
    logic [4:0] cc_at_done;
    logic       te_at_done;

    int   cur_img = 0;
    int   wcnt, run_len, since_fetch;
    logic prev_nnr, prev_valid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Synchronous ROM: data and label appear one cycle after the address.
    always @(posedge clk) begin
        imgData  <= rom_img[imgAddr];
        imgLabel <= rom_lbl[imgAddr];
    end

    // Monitor then network model, both on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            maxValid    = 1'b0;
            wcnt        = 0;
            run_len     = 0;
            prev_valid  = 1'b0;
            prev_nnr    = 1'b0;
            since_fetch = 99;
        end else begin
            if (nnReset) begin
                check("nnreset_single", 64'(prev_nnr), 64'd0);
                check("nnreset_busy", 64'(busy), 64'd1);
                check("nnreset_vs_nnvalid", 64'(NNvalid), 64'd0);
                cur_img     = int'(imgAddr);
                since_fetch = 0;
            end else begin
                since_fetch++;
            end
            if (NNvalid && !prev_valid) check("fetch_to_wait_gap", 64'(since_fetch), 64'd2);
            if (NNvalid) begin
                run_len++;
                check("nnin_rom_word", 64'(NNin), 64'(rom_img[cur_img]));
                check("wait_busy", 64'(busy), 64'd1);
            end else if (prev_valid) begin
                ob_wlen.push_back(run_len);
                run_len = 0;
            end
            if (resultValid) begin
                ob_img.push_back(resultImg);
                ob_cls.push_back(resultClass);
                ob_score.push_back(resultScore);
                ob_hit.push_back(resultHit);
                check("record_nnvalid_low", 64'(NNvalid), 64'd0);
            end
            if (done) begin
                done_cnt++;
                cc_at_done = correctCount;
                te_at_done = timeoutErr;
            end
            prev_nnr   = nnReset;
            prev_valid = NNvalid;

            maxValid = 1'b0;
            maxIndex = 4'($urandom);
            maxValue = 8'($urandom);
            if (NNvalid) begin
                wcnt++;
                if (wcnt == lat[cur_img]) begin
                    maxValid = 1'b1;
                    maxIndex = cls[cur_img];
                    maxValue = val[cur_img];
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic clear_obs();
        ob_img.delete(); ob_cls.delete(); ob_score.delete();
        ob_hit.delete(); ob_wlen.delete();
        done_cnt = 0;
    endtask

    // Fresh ROM; network answers the correct label after l cycles (l<0: random).
    task automatic cfg_correct(input int l);
        for (int i = 0; i < 16; i++) begin
            rom_img[i] = W'($urandom);
            rom_lbl[i] = 4'($urandom);
            lat[i]     = (l < 0) ? int'($urandom_range(1, 40)) : l;
            cls[i]     = rom_lbl[i];
            val[i]     = 8'($urandom);
        end
    endtask

    task automatic wait_done_cnt(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("done_pulses", 64'(done_cnt), 64'd1);
    endtask

    task automatic run_batch(input bit pulse_mid);
        int n = 0;
        clear_obs();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        if (pulse_mid) begin
            while (!NNvalid && n < 100) begin
                @(negedge clk);
                n++;
            end
            start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        wait_done_cnt(3000);
    endtask

    // Expected batch outcome derived from the per-image answer rules.
    task automatic verify_batch(input string name);
        int   hits = 0;
        logic tmo  = 1'b0;
        check({name, "_result_count"}, 64'(ob_img.size()), 64'(NIMG));
        check({name, "_wait_count"}, 64'(ob_wlen.size()), 64'(NIMG));
        for (int i = 0; i < NIMG; i++) begin
            bit         answered = (lat[i] >= 1) && (lat[i] <= TMO);
            logic [3:0] e_cls    = answered ? cls[i] : 4'hF;
            logic [7:0] e_score  = answered ? val[i] : 8'd0;
            logic       e_hit    = answered && (cls[i] == rom_lbl[i]);
            int         e_wlen   = answered ? lat[i] : TMO;
            hits += int'(e_hit);
            tmo  |= !answered;
            if (i < ob_img.size()) begin
                check($sformatf("%s_img[%0d]", name, i), 64'(ob_img[i]), 64'(i));
                check($sformatf("%s_class[%0d]", name, i), 64'(ob_cls[i]), 64'(e_cls));
                check($sformatf("%s_score[%0d]", name, i), 64'(ob_score[i]), 64'(e_score));
                check($sformatf("%s_hit[%0d]", name, i), 64'(ob_hit[i]), 64'(e_hit));
            end
            if (i < ob_wlen.size())
                check($sformatf("%s_wait_len[%0d]", name, i), 64'(ob_wlen[i]), 64'(e_wlen));
        end
        check({name, "_count_at_done"}, 64'(cc_at_done), 64'(hits));
        check({name, "_tmo_at_done"}, 64'(te_at_done), 64'(tmo));
        check({name, "_count_held"}, 64'(correctCount), 64'(hits));
        check({name, "_tmo_held"}, 64'(timeoutErr), 64'(tmo));
        check({name, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic check_zero(input string name);
        check({name, "_nnReset"}, 64'(nnReset), 64'd0);
        check({name, "_NNvalid"}, 64'(NNvalid), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_done"}, 64'(done), 64'd0);
        check({name, "_resultValid"}, 64'(resultValid), 64'd0);
        check({name, "_resultImg"}, 64'(resultImg), 64'd0);
        check({name, "_resultClass"}, 64'(resultClass), 64'd0);
        check({name, "_resultScore"}, 64'(resultScore), 64'd0);
        check({name, "_resultHit"}, 64'(resultHit), 64'd0);
        check({name, "_correctCount"}, 64'(correctCount), 64'd0);
        check({name, "_timeoutErr"}, 64'(timeoutErr), 64'd0);
        check({name, "_NNin"}, 64'(NNin), 64'd0);
        check({name, "_imgAddr"}, 64'(imgAddr), 64'd0);
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        start    = 1'b0;
        maxValid = 1'b0;
        maxIndex = 4'd0;
        maxValue = 8'd0;
        clear_obs();
        cfg_correct(20);
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        // Nominal batch: every image answered correctly after 20 cycles.
        cfg_correct(20);
        run_batch(1'b0);
        verify_batch("nominal");

        // Image 2 labelled 7 but classified as 3.
        cfg_correct(-1);
        rom_lbl[2] = 4'd7;
        cls[2]     = 4'd3;
        run_batch(1'b0);
        verify_batch("misclass");

        // Network never answers image 5.
        cfg_correct(-1);
        lat[5] = 0;
        run_batch(1'b0);
        verify_batch("timeout");

        // Answer on the final timeout cycle; start pulsed during WAIT.
        cfg_correct(-1);
        lat[3] = TMO;
        run_batch(1'b1);
        verify_batch("simul");

        // Asynchronous reset during WAIT of image 4 aborts the batch.
        cfg_correct(30);
        clear_obs();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!(NNvalid && cur_img == 4) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("midreset_reached_img4", 64'(cur_img), 64'd4);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_zero("midreset");
        @(negedge clk); reset = 1'b0;
        repeat (10) @(negedge clk);
        check("midreset_results", 64'(ob_img.size()), 64'd4);
        check("midreset_no_done", 64'(done_cnt), 64'd0);
        run_batch(1'b0);
        verify_batch("after_reset");

        // Start held high restarts from the IDLE cycle after DONE.
        cfg_correct(-1);
        clear_obs();
        @(negedge clk); start = 1'b1;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("held_done_seen", 64'(done), 64'd1);
        @(negedge clk);
        check("held_idle_nnreset", 64'(nnReset), 64'd0);
        verify_batch("held_first");
        clear_obs();
        @(negedge clk);
        check("held_restart_nnreset", 64'(nnReset), 64'd1);
        check("held_restart_busy", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done_cnt(3000);
        verify_batch("held_second");

        // Randomized batches with mixed answers, misses and timeouts.
        for (int b = 0; b < 4; b++) begin
            cfg_correct(-1);
            for (int i = 0; i < 16; i++) begin
                lat[i] = int'($urandom_range(0, 70));
                if ($urandom_range(0, 1) == 0) cls[i] = 4'($urandom);
            end
            run_batch(b[0]);
            verify_batch($sformatf("rand%0d", b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nn_batch_sequencer.md
NN_BATCH_SEQUENCER -- requirements
Module: nn_batch_sequencer

Interface
REQ-001 SHALL have parameter dataWidth, default 8, meaning bits per pixel.
REQ-002 SHALL have parameter numInputs, default 784, meaning pixels per image.
REQ-003 SHALL have parameter numImages, default 8, meaning images per batch, range 1..16.
REQ-004 SHALL have parameter timeoutCycles, default 4096, meaning the maximum number of WAIT cycles per image.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, batch start request, sampled in IDLE only.
REQ-008 SHALL have port imgAddr, output, 4, image/label ROM address.
REQ-009 SHALL have port imgData, input, numInputs*dataWidth, ROM image word, valid 1 cycle after imgAddr.
REQ-010 SHALL have port imgLabel, input, 4, ROM label, with the same latency as imgData.
REQ-011 SHALL have port nnReset, output, 1, one-cycle reset pulse to the NeuralNetwork.
REQ-012 SHALL have port NNin, output, numInputs*dataWidth, registered network input.
REQ-013 SHALL have port NNvalid, output, 1, network input valid.
REQ-014 SHALL have ports maxValid (input, 1), maxIndex (input, 4) and maxValue (input, 8), the network argmax result.
REQ-015 SHALL have ports busy (output, 1) and done (output, 1); done is a one-cycle pulse.
REQ-016 SHALL have ports resultValid (output, 1), resultImg (output, 4), resultClass (output, 4), resultScore (output, 8) and resultHit (output, 1), the per-image result, valid for one cycle.
REQ-017 SHALL have ports correctCount (output, 5) and timeoutErr (output, 1, sticky).

Function
REQ-018 SHALL implement the states IDLE, FETCH, LOAD, WAIT, RECORD and DONE.
REQ-019 IDLE: when start=1, SHALL clear idx, correctCount and timeoutErr and go to FETCH on the next edge.
REQ-020 IDLE: when start=0, SHALL stay in IDLE.
REQ-021 FETCH (1 cycle): SHALL drive imgAddr=idx and nnReset=1, then go to LOAD.
REQ-022 LOAD (1 cycle): SHALL register imgData into NNin and imgLabel into the label register, clear the timeout counter, then go to WAIT.
REQ-023 WAIT: SHALL hold NNvalid=1 and keep NNin stable.
REQ-024 WAIT: SHALL increment the timeout counter each cycle that maxValid=0.
REQ-025 WAIT: on maxValid=1, SHALL capture maxIndex and maxValue and go to RECORD.
REQ-026 WAIT: when the counter reaches timeoutCycles-1 with maxValid=0, SHALL set class=4'hF, score=0, set timeoutErr and go to RECORD.
REQ-027 WAIT: when maxValid=1 and the timeout are both true in the same cycle, maxValid SHALL win.
REQ-028 NNvalid SHALL be 0 in every state except WAIT, and SHALL deassert on the cycle after maxValid is sampled.
REQ-029 RECORD (1 cycle): SHALL drive resultValid=1 with resultImg=idx, resultClass, resultScore, and resultHit=(class==label) & no-timeout.
REQ-030 RECORD: SHALL increment correctCount when resultHit=1; correctCount is visible the cycle after RECORD.
REQ-031 RECORD: when idx==numImages-1, SHALL go to DONE; otherwise SHALL increment idx and go to FETCH.
REQ-032 DONE (1 cycle): SHALL drive done=1, then go to IDLE.
REQ-033 correctCount and timeoutErr SHALL hold their values until the next accepted start.
REQ-034 busy SHALL be 1 in every state except IDLE.
REQ-035 start while busy SHALL be ignored; start held high SHALL restart a new batch from the IDLE cycle after DONE.
REQ-036 Per-image latency SHALL be 3 cycles plus the NeuralNetwork latency (FETCH, LOAD, RECORD overhead).
REQ-037 A timeout SHALL NOT stop the batch; the remaining images SHALL still be processed.
REQ-038 Counter widths SHALL NOT overflow: idx is at most 15, correctCount is at most 16, and the timeout counter is clog2(timeoutCycles) bits.

Reset
REQ-039 While reset=1, state SHALL be IDLE and idx, NNin, the timeout counter, correctCount and timeoutErr SHALL be 0.
REQ-040 While reset=1, nnReset, NNvalid, busy, done, resultValid, resultImg, resultClass, resultScore and resultHit SHALL be 0.
REQ-041 Reset SHALL take effect immediately, asynchronously, in any state, including mid-WAIT; no result or done is emitted for the aborted batch.

Verification
REQ-042 Nominal batch: numImages=8, NN model answers the label after 20 cycles for every image -> 8 resultValid pulses, resultImg 0..7, resultHit=1 each, correctCount=8, done once, timeoutErr=0.
REQ-043 Misclassification: model returns class 3 for the image labelled 7 (idx 2), all others correct -> resultHit=0 at idx 2, final correctCount=7.
REQ-044 Timeout: timeoutCycles=64, model never asserts maxValid for idx 5 -> WAIT lasts exactly 64 cycles, resultClass=4'hF, timeoutErr=1, batch completes, correctCount=7.
REQ-045 Simultaneous events: maxValid asserted on the final timeout cycle -> result taken from maxIndex and timeoutErr stays 0; start pulsed during WAIT -> no effect on the batch.
REQ-046 Reset mid-operation: reset asserted during WAIT of idx 4 -> all outputs 0 within the reset assertion; a subsequent start runs a full batch from idx 0.
REQ-047 Handshake timing: check nnReset is high only in FETCH and NNvalid is high only in WAIT; NNin equals ROM word idx throughout WAIT.
